// File: rtl/gpio_mmio_if.sv
// Processor data-bus view of the GPIO register window: write strobe, byte address,
// write data, plus the combinational read data and window-hit returned by the peripheral.
interface gpio_mmio_if;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        hit;

  modport master (output we, addr, wdata, input rdata, hit);
  modport slave  (input we, addr, wdata, output rdata, hit);
endinterface

// File: rtl/gpio_mmio.sv
// Memory-mapped GPIO: synchronised switches with rising-edge capture/irq, LEDs with set/clr/toggle.
// Writes land on the sampling edge, reads are combinational, no backpressure; GPIO_DEBOUNCE_EN adds DB_CYCLES of switch filtering.
module gpio_mmio #(
  parameter int          NUM_SW    = 10,
  parameter int          NUM_LED   = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0400,
  parameter int          DB_CYCLES = 16
) (
  input  logic               clk,
  input  logic               nreset,
  gpio_mmio_if.slave         bus,
  input  logic [NUM_SW-1:0]  switches,
  output logic [NUM_LED-1:0] leds,
  output logic               irq
);

  localparam logic [2:0] off_sw_in = 3'd0;
  localparam logic [2:0] off_led   = 3'd1;
  localparam logic [2:0] off_set   = 3'd2;
  localparam logic [2:0] off_clr   = 3'd3;
  localparam logic [2:0] off_tgl   = 3'd4;
  localparam logic [2:0] off_edge  = 3'd5;
  localparam logic [2:0] off_mask  = 3'd6;

  logic [NUM_SW-1:0]  s1, s2, prev, sw_val;
  logic [NUM_SW-1:0]  edge_q, mask_q, rise, w1c, edge_next;
  logic [NUM_LED-1:0] led_wd;
  logic [1:0]         warm;
  logic [2:0]         off;
  logic               hit, wr;
  logic [31:0]        rd;

  assign hit    = (bus.addr[31:5] == BASE_ADDR[31:5]) && (bus.addr[1:0] == 2'b00);
  assign off    = bus.addr[4:2];
  assign wr     = bus.we & hit;
  assign led_wd = bus.wdata[NUM_LED-1:0];

  // Edges are ignored until the pipeline has flushed post-reset values, so a switch
  // held high through reset does not look like a fresh rise.
  assign rise      = sw_val & ~prev & {NUM_SW{warm == 2'd3}};
  assign w1c       = (wr && off == off_edge) ? bus.wdata[NUM_SW-1:0] : '0;
  assign edge_next = (edge_q & ~w1c) | rise;

`ifdef GPIO_DEBOUNCE_EN
  localparam int CW = $clog2(DB_CYCLES + 1);
  logic [NUM_SW-1:0][CW-1:0] db_cnt;
  logic [NUM_SW-1:0]         db_q;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      db_cnt <= '0;
      db_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_SW; i++) begin
        if (s2[i] == db_q[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CW'(DB_CYCLES - 1)) begin
          db_q[i]   <= s2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CW'(1);
        end
      end
    end
  end

  assign sw_val = db_q;
`else
  assign sw_val = s2;
`endif

  always_ff @(posedge clk) begin
    if (!nreset) begin
      s1     <= '0;
      s2     <= '0;
      prev   <= '0;
      warm   <= 2'd0;
      edge_q <= '0;
      mask_q <= '0;
      leds   <= '0;
      irq    <= 1'b0;
    end else begin
      s1     <= switches;
      s2     <= s1;
      prev   <= sw_val;
      edge_q <= edge_next;
      irq    <= |(edge_q & mask_q);
      if (warm != 2'd3) warm <= warm + 2'd1;
      if (wr) begin
        case (off)
          off_led:  leds   <= led_wd;
          off_set:  leds   <= leds | led_wd;
          off_clr:  leds   <= leds & ~led_wd;
          off_tgl:  leds   <= leds ^ led_wd;
          off_mask: mask_q <= bus.wdata[NUM_SW-1:0];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rd = '0;
    case (off)
      off_sw_in: rd[NUM_SW-1:0]  = sw_val;
      off_led:   rd[NUM_LED-1:0] = leds;
      off_edge:  rd[NUM_SW-1:0]  = edge_q;
      off_mask:  rd[NUM_SW-1:0]  = mask_q;
      default: ;
    endcase
  end

  assign bus.hit   = hit;
  assign bus.rdata = hit ? rd : 32'd0;

  // Upper write-data bits beyond the configured widths have no destination.
  logic unused_ok;
  assign unused_ok = ^{bus.wdata, (DB_CYCLES > 1)};

endmodule
